// File: rtl/alu_request_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters.
// Grants are registered into ALU operands; results return with a done pulse.
module alu_request_arbiter #(
    parameter int         N_BITS   = 16,
    parameter logic [2:0] NOP_CODE = 3'b111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [N_BITS-1:0] a0,
    input  logic [N_BITS-1:0] b0,
    input  logic [2:0]        op0,
    input  logic [N_BITS-1:0] a1,
    input  logic [N_BITS-1:0] b1,
    input  logic [2:0]        op1,
    output logic [1:0]        done,
    output logic [1:0]        err,
    output logic [N_BITS-1:0] res0,
    output logic [N_BITS-1:0] res1,
    output logic              ovf0,
    output logic              ovf1,
    output logic              busy,
    output logic [N_BITS-1:0] alu_a,
    output logic [N_BITS-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [N_BITS-1:0] alu_result,
    input  logic              alu_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic                gnt_q;
    logic                gnt_d;
    logic                last_q;
    logic [1:0]          done_q;
    logic [1:0]          err_q;
    logic [N_BITS-1:0]   res0_q;
    logic [N_BITS-1:0]   res1_q;
    logic                ovf0_q;
    logic                ovf1_q;
    logic [N_BITS-1:0]   alu_a_q;
    logic [N_BITS-1:0]   alu_b_q;
    logic [2:0]          alu_op_q;
    logic [N_BITS-1:0]   sel_a;
    logic [N_BITS-1:0]   sel_b;
    logic [2:0]          sel_op;

    // Pick the winner: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        gnt_d = 1'b0;
        if (req == 2'b11) begin
            gnt_d = ~last_q;
        end else begin
            gnt_d = req[1];
        end
        sel_a  = gnt_d ? a1  : a0;
        sel_b  = gnt_d ? b1  : b0;
        sel_op = gnt_d ? op1 : op0;
    end

    // Main FSM: grant in IDLE, capture ALU output in EXEC, pulse done in RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            done_q   <= 2'b00;
            err_q    <= 2'b00;
            res0_q   <= '0;
            res1_q   <= '0;
            ovf0_q   <= 1'b0;
            ovf1_q   <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= NOP_CODE;
        end else begin
            done_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        gnt_q    <= gnt_d;
                        alu_a_q  <= sel_a;
                        alu_b_q  <= sel_b;
                        alu_op_q <= sel_op;
                        if (sel_op == NOP_CODE) begin
                            state_q       <= RESP;
                            done_q[gnt_d] <= 1'b1;
                            err_q[gnt_d]  <= 1'b1;
                        end else begin
                            state_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (gnt_q) begin
                        res1_q <= alu_result;
                        ovf1_q <= alu_overflow;
                    end else begin
                        res0_q <= alu_result;
                        ovf0_q <= alu_overflow;
                    end
                    err_q[gnt_q]  <= 1'b0;
                    done_q[gnt_q] <= 1'b1;
                    state_q       <= RESP;
                end
                RESP: begin
                    last_q  <= gnt_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign done   = done_q;
    assign err    = err_q;
    assign res0   = res0_q;
    assign res1   = res1_q;
    assign ovf0   = ovf0_q;
    assign ovf1   = ovf1_q;
    assign busy   = (state_q != IDLE);
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Bench for alu_request_arbiter with an adder stub ALU.
// Transaction-level model predicts winner, latency and per-requester results.
module tb_alu_request_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] a0, b0, a1, b1;
    logic [2:0]  op0, op1;
    logic [1:0]  done, err;
    logic [15:0] res0, res1;
    logic        ovf0, ovf1, busy;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_overflow;

    int checks;
    int errors;

    logic [15:0] m_res [2];
    logic        m_ovf [2];
    logic        m_err [2];
    logic        m_last;

    alu_request_arbiter #(.N_BITS(16), .NOP_CODE(3'b111)) dut (
        .clk(clk), .rst(rst), .req(req),
        .a0(a0), .b0(b0), .op0(op0),
        .a1(a1), .b1(b1), .op1(op1),
        .done(done), .err(err),
        .res0(res0), .res1(res1),
        .ovf0(ovf0), .ovf1(ovf1), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_overflow(alu_overflow)
    );

    assign {alu_overflow, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_res[i] = '0;
            m_ovf[i] = 1'b0;
            m_err[i] = 1'b0;
        end
        m_last = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".res0"}, 32'(res0), 32'(m_res[0]));
        check({tag, ".res1"}, 32'(res1), 32'(m_res[1]));
        check({tag, ".ovf0"}, 32'(ovf0), 32'(m_ovf[0]));
        check({tag, ".ovf1"}, 32'(ovf1), 32'(m_ovf[1]));
        check({tag, ".err"}, 32'(err), 32'({m_err[1], m_err[0]}));
    endtask

    // Called at a negedge with the DUT idle; serves n grants with req held.
    task automatic run(input logic [1:0] r, input int n);
        logic        w;
        logic        nop;
        logic [16:0] sum;
        logic [2:0]  wop;
        int          cnt;
        req = r;
        for (int k = 0; k < n; k++) begin
            w   = (r == 2'b11) ? ~m_last : r[1];
            wop = w ? op1 : op0;
            nop = (wop == 3'b111);
            sum = w ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (done == 2'b00 && cnt < 8);
            check("latency", 32'(cnt), nop ? 32'd1 : 32'd2);
            check("done", 32'(done), w ? 32'd2 : 32'd1);
            check("alu_op", 32'(alu_op), 32'(wop));
            check("busy_resp", 32'(busy), 32'd1);
            if (nop) begin
                m_err[w] = 1'b1;
            end else begin
                m_res[w] = sum[15:0];
                m_ovf[w] = sum[16];
                m_err[w] = 1'b0;
            end
            m_last = w;
            check_state("resp");
            if (k == n - 1) req = 2'b00;
            @(negedge clk);
            check("busy_idle", 32'(busy), 32'd0);
            check("done_idle", 32'(done), 32'd0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        req = 2'b11;
        a0 = 16'h1111; b0 = 16'h2222; op0 = 3'b000;
        a1 = 16'h3333; b1 = 16'h4444; op1 = 3'b000;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst.done", 32'(done), 32'd0);
        check("rst.alu_op", 32'(alu_op), 32'h7);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.alu_a", 32'(alu_a), 32'd0);
        check_state("rst");
        req = 2'b00;
        rst = 1'b1;
        @(negedge clk);

        a0 = 16'h0003; b0 = 16'h0004; op0 = 3'b000;
        run(2'b01, 1);
        check("t2.res0", 32'(res0), 32'h0007);

        a0 = 16'hFFFF; b0 = 16'h0001; op0 = 3'b000;
        a1 = 16'h1234; b1 = 16'h0001; op1 = 3'b000;
        run(2'b11, 3);
        check("t3.res0", 32'(res0), 32'h0000);
        check("t3.ovf0", 32'(ovf0), 32'd1);
        check("t3.res1", 32'(res1), 32'h1235);

        op1 = 3'b111;
        run(2'b10, 1);
        check("t4.err1", 32'(err[1]), 32'd1);
        op1 = 3'b001;
        a1 = 16'h0010; b1 = 16'h0020;
        run(2'b10, 1);
        check("t4.clr", 32'(err[1]), 32'd0);

        a0 = 16'h0100; b0 = 16'h0200; op0 = 3'b000;
        req = 2'b01;
        @(negedge clk);
        rst = 1'b0;
        req = 2'b00;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5.done", 32'(done), 32'd0);
        end
        check_state("t5");
        rst = 1'b1;
        @(negedge clk);
        a0 = 16'h0005; b0 = 16'h0006;
        a1 = 16'h0007; b1 = 16'h0008; op1 = 3'b000;
        run(2'b11, 1);
        check("t5.prio", 32'(res0), 32'h000B);

        a0 = 16'h8000; b0 = 16'h8001; op0 = 3'b010;
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        m_res[0] = 16'h0001;
        m_ovf[0] = 1'b1;
        m_err[0] = 1'b0;
        m_last = 1'b0;
        check("t6.done", 32'(done), 32'd1);
        check_state("t6");
        @(negedge clk);
        check("t6.idle", 32'(busy), 32'd0);

        for (int it = 0; it < 40; it++) begin
            a0  = 16'($urandom);
            b0  = 16'($urandom);
            a1  = 16'($urandom);
            b1  = 16'($urandom);
            op0 = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
            op1 = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
            run(2'($urandom_range(1, 3)), $urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
